// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words from a host stream and
// writes them byte by byte (little-endian) into instruction memory while
// holding the CPU fetch stage. Capacity overruns raise a sticky overflow flag.
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          MEM_BYTES = 152
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        finish,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

  localparam logic [63:0] END_ADDR = BASE_ADDR + 64'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] ptr_q, ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic        fpend_q, fpend_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  cnt_q, cnt_d;

  // State and datapath registers; reset parks the loader idle at BASE_ADDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= BASE_ADDR;
      idx_q   <= 2'd0;
      word_q  <= 32'd0;
      fpend_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      fpend_q <= fpend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode. A finish seen mid-word is remembered so the
  // word completes and the following LOAD cycle goes straight to DONE.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    word_d     = word_q;
    fpend_d    = fpend_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    word_ready = (state_q == LOAD) && !finish && !fpend_q;
    mem_we     = 1'b0;
    mem_addr   = ptr_q;
    mem_wdata  = 8'd0;
    cpu_hold   = (state_q != IDLE);
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = BASE_ADDR;
          cnt_d   = 8'd0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (finish || fpend_q) begin
          state_d = DONE;
          fpend_d = 1'b0;
        end else if (word_valid) begin
          if (ptr_q + 64'd4 <= END_ADDR) begin
            word_d  = word_data;
            idx_d   = 2'd0;
            state_d = WRITE;
          end else begin
            ovf_d   = 1'b1;
            fpend_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q + {62'd0, idx_q};
        mem_wdata = word_q[{idx_q, 3'b000} +: 8];
        if (finish) fpend_d = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          ptr_d   = ptr_q + 64'd4;
          cnt_d   = cnt_q + 8'd1;
          state_d = LOAD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign overflow   = ovf_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of words with hand-computed byte images,
// a write scoreboard fed at word acceptance and drained by a memory monitor,
// plus directed sequences for finish-in-write, overflow and reset-in-write.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, finish = 1'b0, word_valid = 1'b0;
  logic [31:0] word_data = 32'd0;
  logic        word_ready, mem_we, cpu_hold, done, overflow;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata, word_count;

  imem_loader #(.BASE_ADDR(64'd0), .MEM_BYTES(152)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [31:0] w; logic [7:0] b0, b1, b2, b3; } vec_t;

  wr_t         sb_q[$];
  vec_t        tbl[4];
  int          checks = 0, failures = 0, done_cnt = 0, cyc = 0;
  logic [63:0] exp_ptr = 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side monitor: every byte write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (mem_we) begin
        if (sb_q.size() == 0) chk("unexpected_we", mem_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          wr_t e;
          e = sb_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", {56'd0, mem_wdata}, {56'd0, e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!word_ready && n < 20) begin tick(); n++; end
    ok = word_ready;
    if (!ok) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [31:0] w, input logic [7:0] b0, b1, b2, b3,
                      input bit push, output int acc);
    bit ok;
    word_valid = 1'b1;
    word_data  = w;
    acc = -1;
    wait_ready(ok);
    if (ok) begin
      if (push) begin
        sb_q.push_back('{exp_ptr + 64'd0, b0});
        sb_q.push_back('{exp_ptr + 64'd1, b1});
        sb_q.push_back('{exp_ptr + 64'd2, b2});
        sb_q.push_back('{exp_ptr + 64'd3, b3});
        exp_ptr = exp_ptr + 64'd4;
      end
      tick();
      acc = cyc;
    end
    word_valid = 1'b0;
  endtask

  task automatic begin_session();
    start = 1'b1; tick(); start = 1'b0;
    exp_ptr = 64'd0;
  endtask

  task automatic end_session(input logic [7:0] exp_cnt);
    bit ok;
    wait_ready(ok);
    finish = 1'b1; #1;
    chk("ready_during_finish", {63'd0, word_ready}, 64'd0);
    tick(); finish = 1'b0;
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("count_at_done", {56'd0, word_count}, {56'd0, exp_cnt});
    tick();
    chk("done_low", {63'd0, done}, 64'd0);
    chk("hold_released", {63'd0, cpu_hold}, 64'd0);
  endtask

  initial begin
    int acc, prev;
    logic [31:0] w;
    tbl[0] = '{32'h00600593, 8'h93, 8'h05, 8'h60, 8'h00};
    tbl[1] = '{32'h00B50533, 8'h33, 8'h05, 8'hB5, 8'h00};
    tbl[2] = '{32'hFFF28293, 8'h93, 8'h82, 8'hF2, 8'hFF};
    tbl[3] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

    // Reset values
    #2;
    chk("rst_ready", {63'd0, word_ready}, 64'd0);
    chk("rst_we", {63'd0, mem_we}, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", {56'd0, mem_wdata}, 64'd0);
    chk("rst_hold", {63'd0, cpu_hold}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    chk("rst_count", {56'd0, word_count}, 64'd0);
    tick(); reset = 1'b0; tick();
    chk("idle_hold", {63'd0, cpu_hold}, 64'd0);

    // Table-driven session, back-to-back words, start pulses ignored
    begin_session();
    chk("load_hold", {63'd0, cpu_hold}, 64'd1);
    chk("load_ready", {63'd0, word_ready}, 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_in_load_count", {56'd0, word_count}, 64'd0);
    chk("start_in_load_ready", {63'd0, word_ready}, 64'd1);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].w, tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].b3, 1'b1, acc);
      if (i > 0) chk("b2b_gap", 64'(acc - prev), 64'd5);
      prev = acc;
      if (i == 1) begin
        chk("write_we", {63'd0, mem_we}, 64'd1);
        start = 1'b1; tick(); start = 1'b0;
      end
    end
    end_session(8'd4);

    // finish pulsed during the second word's WRITE
    begin_session();
    send(tbl[0].w, tbl[0].b0, tbl[0].b1, tbl[0].b2, tbl[0].b3, 1'b1, acc);
    send(tbl[1].w, tbl[1].b0, tbl[1].b1, tbl[1].b2, tbl[1].b3, 1'b1, acc);
    finish = 1'b1; tick(); finish = 1'b0;
    tick(); tick(); tick();
    chk("pend_ready_low", {63'd0, word_ready}, 64'd0);
    chk("pend_hold", {63'd0, cpu_hold}, 64'd1);
    chk("pend_no_done", {63'd0, done}, 64'd0);
    tick();
    chk("pend_done", {63'd0, done}, 64'd1);
    chk("pend_count", {56'd0, word_count}, 64'd2);
    tick();

    // Overflow: 38 words fill memory, 39th is dropped
    begin_session();
    for (int i = 0; i < 38; i++) begin
      w = $urandom;
      send(w, w[7:0], w[15:8], w[23:16], w[31:24], 1'b1, acc);
    end
    w = $urandom;
    send(w, w[7:0], w[15:8], w[23:16], w[31:24], 1'b0, acc);
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_done", {63'd0, done}, 64'd1);
    chk("ovf_count", {56'd0, word_count}, 64'd38);
    chk("ovf_no_we", {63'd0, mem_we}, 64'd0);
    tick();
    chk("ovf_sticky_idle", {63'd0, overflow}, 64'd1);
    chk("ovf_count_idle", {56'd0, word_count}, 64'd38);
    chk("ovf_hold_idle", {63'd0, cpu_hold}, 64'd0);

    // Reset during WRITE index 2: only bytes 0 and 1 reach memory
    begin_session();
    chk("new_session_ovf_clr", {63'd0, overflow}, 64'd0);
    send(tbl[3].w, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, acc);
    sb_q.push_back('{64'd0, tbl[3].b0});
    sb_q.push_back('{64'd1, tbl[3].b1});
    tick(); tick();
    chk("idx2_we", {63'd0, mem_we}, 64'd1);
    chk("idx2_addr", mem_addr, 64'd2);
    reset = 1'b1; #1;
    chk("rst_mid_we", {63'd0, mem_we}, 64'd0);
    chk("rst_mid_addr", mem_addr, 64'd0);
    chk("rst_mid_hold", {63'd0, cpu_hold}, 64'd0);
    tick(); tick(); reset = 1'b0;
    chk("post_rst_count", {56'd0, word_count}, 64'd0);
    chk("post_rst_ready", {63'd0, word_ready}, 64'd0);
    tick(); tick(); tick();
    chk("post_rst_we", {63'd0, mem_we}, 64'd0);
    begin_session();
    send(tbl[2].w, tbl[2].b0, tbl[2].b1, tbl[2].b2, tbl[2].b3, 1'b1, acc);
    end_session(8'd1);

    tick(); tick();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
